// File: rtl/calc_sequencer.sv
// Operand-entry and dispatch controller: button-driven chunk entry, unit request/response, result store/fetch.
// Latency: one state per press; ISSUE holds req_valid until req_ready; WAIT aborts after TIMEOUT cycles.
// Backpressure: req_valid stays asserted while req_ready is low; presses are ignored in ISSUE/WAIT/DONE.
module calc_sequencer #(
    parameter int DATA_W   = 64,
    parameter int CHUNK_W  = 16,
    parameter int NUM_REGS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic [CHUNK_W-1:0] switches,
    output logic [1:0]         unit_sel,
    output logic [2:0]         op_sel,
    output logic [DATA_W-1:0]  opa,
    output logic [DATA_W-1:0]  opb,
    output logic               req_valid,
    input  logic               req_ready,
    input  logic               rsp_valid,
    input  logic [DATA_W-1:0]  rsp_data,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               sign,
    output logic               busy,
    output logic               timeout_err,
    output logic [2:0]         state_dbg
);
    localparam int NCH_MAX = DATA_W / CHUNK_W;
    localparam int CNT_W   = $clog2(NCH_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int WCNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_OP = 3'd1, S_SIZE = 3'd2, S_OPA = 3'd3,
        S_OPB = 3'd4, S_ISSUE = 3'd5, S_WAIT = 3'd6, S_DONE = 3'd7
    } state_t;

    state_t              state, state_nxt;
    logic                btn_q, armed, press;
    logic [2:0]          mode;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    nchunks, chunk_cnt;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [DATA_W-1:0]   rsp_q, result_q, new_val;
    logic                sign_q, sign_new;
    logic                is_fetch, is_store, is_single, last_chunk, mode_ok, timeout_hit;

    function automatic logic [CNT_W-1:0] nch_of(input logic [1:0] s);
        int n;
        n = 1 << s;
        if (n > NCH_MAX) n = NCH_MAX;
        return CNT_W'(n);
    endfunction

    // armed masks the first cycle after reset so a button held through reset is not a press
    assign press       = btn & ~btn_q & armed;
    assign is_fetch    = (mode == 3'b100);
    assign is_store    = (mode == 3'b101);
    assign is_single   = (mode == 3'b001 && op_sel == 3'b101) || (mode == 3'b011 && op_sel == 3'b110);
    assign last_chunk  = (chunk_cnt == nchunks - CNT_W'(1));
    assign mode_ok     = (switches[2:1] != 2'b11);
    assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT - 1));

    assign unit_sel     = mode[2] ? 2'd0 : mode[1:0];
    assign req_valid    = (state == S_ISSUE);
    assign result_valid = (state == S_DONE);
    assign busy         = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DONE);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (press && mode_ok) state_nxt = S_OP;
            S_OP:    if (press) state_nxt = is_fetch ? S_DONE : S_SIZE;
            S_SIZE:  if (press) state_nxt = S_OPA;
            S_OPA:   if (press && last_chunk)
                         state_nxt = is_store ? S_DONE : (is_single ? S_ISSUE : S_OPB);
            S_OPB:   if (press && last_chunk) state_nxt = S_ISSUE;
            S_ISSUE: if (req_ready) state_nxt = rsp_valid ? S_DONE : S_WAIT;
            S_WAIT:  if (rsp_valid || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // DONE bypasses the new value straight to result/sign in the same cycle
    always_comb begin
        new_val = rsp_q;
        if (is_store)      new_val = opa;
        else if (is_fetch) new_val = mem[idx];
        sign_new = new_val[CHUNK_W-1];
        for (int k = 1; k <= NCH_MAX; k++)
            if (nchunks == CNT_W'(k)) sign_new = new_val[k*CHUNK_W-1];
        if (is_fetch) sign_new = new_val[DATA_W-1];
        result = (state == S_DONE) ? new_val  : result_q;
        sign   = (state == S_DONE) ? sign_new : sign_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q       <= 1'b0;
            armed       <= 1'b0;
            mode        <= '0;
            op_sel      <= '0;
            idx         <= '0;
            nchunks     <= '0;
            chunk_cnt   <= '0;
            wait_cnt    <= '0;
            opa         <= '0;
            opb         <= '0;
            rsp_q       <= '0;
            result_q    <= '0;
            sign_q      <= 1'b0;
            timeout_err <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
        end else begin
            btn_q <= btn;
            armed <= 1'b1;
            case (state)
                S_IDLE: if (press) begin
                    timeout_err <= 1'b0;
                    if (mode_ok) mode <= switches[2:0];
                end
                S_OP: if (press) begin
                    op_sel <= switches[2:0];
                    idx    <= switches[IDX_W-1:0];
                end
                S_SIZE: if (press) begin
                    nchunks   <= nch_of(switches[1:0]);
                    opa       <= '0;
                    opb       <= '0;
                    chunk_cnt <= '0;
                end
                S_OPA: if (press) begin
                    for (int k = 0; k < NCH_MAX; k++)
                        if (chunk_cnt == CNT_W'(k)) opa[k*CHUNK_W +: CHUNK_W] <= switches;
                    chunk_cnt <= last_chunk ? '0 : chunk_cnt + CNT_W'(1);
                end
                S_OPB: if (press) begin
                    for (int k = 0; k < NCH_MAX; k++)
                        if (chunk_cnt == CNT_W'(k)) opb[k*CHUNK_W +: CHUNK_W] <= switches;
                    chunk_cnt <= last_chunk ? '0 : chunk_cnt + CNT_W'(1);
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    if (req_ready && rsp_valid) rsp_q <= rsp_data;
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        rsp_q <= rsp_data;
                    end else if (timeout_hit) begin
                        rsp_q       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_DONE: begin
                    result_q <= new_val;
                    sign_q   <= sign_new;
                    if (is_store) mem[idx] <= opa;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: table of full transactions plus store/fetch, timeout, zero-latency and reset sequences.
module tb_calc_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b0;
    logic [15:0] switches = '0;
    logic [1:0]  unit_sel;
    logic [2:0]  op_sel;
    logic [63:0] opa, opb, rsp_data, result;
    logic        req_valid, req_ready, rsp_valid, result_valid, sign, busy, timeout_err;
    logic [2:0]  state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    calc_sequencer dut (
        .clk(clk), .rst(rst), .btn(btn), .switches(switches),
        .unit_sel(unit_sel), .op_sel(op_sel), .opa(opa), .opb(opb),
        .req_valid(req_valid), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .result(result), .result_valid(result_valid),
        .sign(sign), .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [2:0]  op;
        logic [1:0]  size;
        logic        single;
        logic [63:0] a;
        logic [63:0] b;
        int          lat;
        logic [63:0] rsp;
        logic [1:0]  e_unit;
        logic [63:0] e_opa;
        logic [63:0] e_opb;
        logic [63:0] e_res;
        logic        e_sign;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic press(input logic [15:0] v);
        @(negedge clk);
        switches = v;
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic enter_ops(input logic [2:0] m, input logic [2:0] op, input logic [1:0] sz,
                             input logic [63:0] a, input logic [63:0] b, input logic single);
        int n;
        n = 1 << sz;
        if (n > 4) n = 4;
        press({13'd0, m});
        press({13'd0, op});
        press({14'd0, sz});
        for (int k = 0; k < n; k++) press(a[k*16 +: 16]);
        if (!single)
            for (int k = 0; k < n; k++) press(b[k*16 +: 16]);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        string t;
        t = $sformatf("v%0d", i);
        enter_ops(v.mode, v.op, v.size, v.a, v.b, v.single);
        chk({t, "_state_issue"}, 64'(state_dbg), 64'd5);
        chk({t, "_req_valid"}, 64'(req_valid), 64'd1);
        chk({t, "_unit_sel"}, 64'(unit_sel), 64'(v.e_unit));
        chk({t, "_op_sel"}, 64'(op_sel), 64'(v.op));
        chk({t, "_opa"}, opa, v.e_opa);
        chk({t, "_opb"}, opb, v.e_opb);
        press(16'h0007);
        chk({t, "_press_ignored_issue"}, 64'(state_dbg), 64'd5);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk({t, "_state_wait"}, 64'(state_dbg), 64'd6);
        repeat (v.lat - 1) @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = v.rsp;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = '0;
        chk({t, "_state_done"}, 64'(state_dbg), 64'd7);
        chk({t, "_result"}, result, v.e_res);
        chk({t, "_result_valid"}, 64'(result_valid), 64'd1);
        chk({t, "_sign"}, 64'(sign), 64'(v.e_sign));
        @(negedge clk);
        chk({t, "_back_idle"}, 64'(state_dbg), 64'd0);
        chk({t, "_rv_pulse"}, 64'(result_valid), 64'd0);
        chk({t, "_result_hold"}, result, v.e_res);
        chk({t, "_sign_hold"}, 64'(sign), 64'(v.e_sign));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;

        vecs[0] = '{3'd1, 3'd0, 2'd1, 1'b0, 64'h0001_0002, 64'h3, 3, 64'h0001_0005,
                    2'd1, 64'h0001_0002, 64'h3, 64'h0001_0005, 1'b0};
        vecs[1] = '{3'd3, 3'd6, 2'd0, 1'b1, 64'h00FF, 64'h0, 1, 64'hFF00,
                    2'd3, 64'h00FF, 64'h0, 64'hFF00, 1'b1};
        vecs[2] = '{3'd2, 3'd3, 2'd2, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h4, 2, 64'h8000_0000_0000_0000,
                    2'd2, 64'h1234_5678_9ABC_DEF0, 64'h4, 64'h8000_0000_0000_0000, 1'b1};
        vecs[3] = '{3'd0, 3'd1, 2'd3, 1'b0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 5,
                    64'h4008_0000_0000_0000, 2'd0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
                    64'h4008_0000_0000_0000, 1'b0};
        vecs[4] = '{3'd1, 3'd5, 2'd0, 1'b1, 64'h0007, 64'h0, 4, 64'hFFF9,
                    2'd1, 64'h0007, 64'h0, 64'hFFF9, 1'b1};

        #13;
        chk("reset_state", 64'(state_dbg), 64'd0);
        chk("reset_req_valid", 64'(req_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_opa", opa, 64'd0);
        chk("reset_sign", 64'(sign), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // store reg 2, then fetch it back
        enter_ops(3'd5, 3'd2, 2'd2, 64'h8000_0000_0000_0001, 64'h0, 1'b1);
        chk("store_done", 64'(state_dbg), 64'd7);
        chk("store_result", result, 64'h8000_0000_0000_0001);
        chk("store_sign", 64'(sign), 64'd1);
        chk("store_no_req", 64'(req_valid), 64'd0);
        press(16'd4);
        press(16'd2);
        chk("fetch_done", 64'(state_dbg), 64'd7);
        chk("fetch_result", result, 64'h8000_0000_0000_0001);
        chk("fetch_sign", 64'(sign), 64'd1);
        chk("fetch_no_req", 64'(req_valid), 64'd0);
        chk("fetch_rv", 64'(result_valid), 64'd1);
        press(16'd4);
        press(16'd1);
        chk("fetch_empty_reg", result, 64'd0);

        // timeout
        enter_ops(3'd0, 3'd0, 2'd0, 64'h1, 64'h1, 1'b0);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        c = 0;
        while (state_dbg != 3'd7 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_cycles", 64'(c), 64'd255);
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
        chk("timeout_result", result, 64'd0);
        chk("timeout_rv", 64'(result_valid), 64'd1);
        @(negedge clk);
        chk("timeout_idle", 64'(state_dbg), 64'd0);
        chk("timeout_sticky", 64'(timeout_err), 64'd1);
        press(16'd7);
        chk("illegal_mode_idle", 64'(state_dbg), 64'd0);
        chk("timeout_err_cleared", 64'(timeout_err), 64'd0);

        // zero-latency response
        enter_ops(3'd1, 3'd0, 2'd0, 64'h1, 64'h2, 1'b0);
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 64'h3;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        chk("zl_done", 64'(state_dbg), 64'd7);
        chk("zl_result", result, 64'h3);
        chk("zl_sign", 64'(sign), 64'd0);
        @(negedge clk);

        // reset mid-WAIT
        enter_ops(3'd1, 3'd0, 2'd0, 64'h5, 64'h6, 1'b0);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("rw_in_wait", 64'(state_dbg), 64'd6);
        #2 rst = 1'b0;
        #1;
        chk("rw_state", 64'(state_dbg), 64'd0);
        chk("rw_req_valid", 64'(req_valid), 64'd0);
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_opa", opa, 64'd0);
        chk("rw_unit_sel", 64'(unit_sel), 64'd0);
        chk("rw_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        press(16'd4);
        press(16'd2);
        chk("rw_mem_cleared", result, 64'd0);
        @(negedge clk);

        // reset mid-chunk entry with button held through reset
        press(16'd1);
        press(16'd0);
        press(16'd2);
        press(16'hAAAA);
        chk("rc_in_opa", 64'(state_dbg), 64'd3);
        @(negedge clk);
        switches = 16'd1;
        btn = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rc_state", 64'(state_dbg), 64'd0);
        chk("rc_opa", opa, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rc_no_spurious", 64'(state_dbg), 64'd0);
        btn = 1'b0;
        @(negedge clk);
        chk("rc_still_idle", 64'(state_dbg), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Parametrised operand-entry and dispatch controller for the calculator datapath.
- Collects mode, operation, operand size and operands from switches and a button, one CHUNK_W-bit chunk per press.
- Issues the request to the selected execution unit over a valid/ready handshake and waits for a response with a timeout.
- Holds a NUM_REGS-deep result register file for store/fetch, and drives the result and sign LED.

Parameters:
DATA_W, 64, operand/result width; multiple of CHUNK_W
CHUNK_W, 16, switch entry width per button press
NUM_REGS, 4, store/fetch register count; power of 2, >=2
TIMEOUT, 255, max cycles in WAIT before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn  in  1  debounced confirm button (level); block edge-detects internally
switches  in  CHUNK_W  entry value
unit_sel  out  2  selected unit: 0 FPU, 1 arith, 2 bit-manip, 3 logic
op_sel  out  3  operation code to unit
opa, opb  out  DATA_W  operands, stable from ISSUE until response
req_valid  out  1  request valid
req_ready  in  1  unit accepts request
rsp_valid  in  1  unit result valid (one-cycle pulse)
rsp_data  in  DATA_W  unit result
result  out  DATA_W  last result
result_valid  out  1  one-cycle pulse in DONE
sign  out  1  MSB of result at selected size
busy  out  1  high in ISSUE/WAIT/DONE
timeout_err  out  1  sticky abort flag
state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; opa/opb/mem/size/counters cleared; btn_q=0.
- press = btn & ~btn_q; one advance per rising edge; presses are ignored in ISSUE, WAIT and DONE.
- States: IDLE=0, OP=1, SIZE=2, OPA=3, OPB=4, ISSUE=5, WAIT=6, DONE=7.
- IDLE:
  - On press, mode=switches[2:0] and timeout_err clears.
  - Modes 000–011 select unit 0–3; 100 is fetch; 101 is store.
  - Modes 110/111 are ignored: stay in IDLE.
- OP: on press, op_sel=switches[2:0]; idx=switches[log2(NUM_REGS)-1:0]. Fetch → DONE, all others → SIZE.
- SIZE:
  - On press, size_sel=switches[1:0].
  - nchunks = min(2^size_sel, DATA_W/CHUNK_W).
  - opa and opb clear to 0; chunk count clears; → OPA.
- OPA/OPB:
  - Press k writes switches into bits [k*CHUNK_W +: CHUNK_W]; unfilled upper bits stay 0.
  - After nchunks presses, OPA goes → OPB, except store → DONE and single-operand ops (arith 101, logic 110) → ISSUE.
  - OPB goes → ISSUE after nchunks presses.
- ISSUE:
  - req_valid=1 until the cycle req_ready=1, then → WAIT with wait counter=0.
  - If rsp_valid and req_ready are high in the same cycle, treat as zero-latency: capture rsp_data, → DONE.
- WAIT:
  - Counter increments each cycle.
  - rsp_valid captures rsp_data into result, → DONE.
  - If the counter reaches TIMEOUT without rsp_valid: result=0, timeout_err=1, → DONE.
  - rsp_valid outside WAIT/ISSUE is ignored.
- DONE (one cycle):
  - Store: mem[idx]=opa, result=opa.
  - Fetch: result=mem[idx].
  - result_valid=1. sign=result[min(CHUNK_W*nchunks, DATA_W)-1]; for fetch, sign=result[DATA_W-1].
  - → IDLE.
- result and sign hold until the next DONE. Bypass: in DONE, result is the new value in that same cycle (sign updates with it).

Test Plan:
- Arith add, size 1 (2 chunks), A=0x0001_0002, B=0x0000_0003:
  - unit_sel=1, op_sel=0, opa=0x00010002, opb=3.
  - req_valid held until req_ready; rsp_data=0x00010005 after 3 cycles.
  - result=0x00010005, result_valid pulses once, sign=0.
- Store then fetch, reg 2:
  - Store with size 2 (64-bit), A=0x8000_0000_0000_0001, reg 2.
  - Fetch reg 2 → result=0x8000000000000001, sign=1, no req_valid.
- Timeout: FPU op, req_ready=1, rsp_valid never asserted.
  - At TIMEOUT cycles after accept: timeout_err=1, result=0, back to IDLE.
  - Next mode press clears timeout_err.
- Single-operand logic NOT (op 110), size 0, A=0x00FF:
  - OPB skipped; opb=0; request issued after one operand chunk.
- Async reset asserted mid-WAIT, and at mid-chunk entry:
  - Immediately: state=IDLE, outputs 0, mem cleared.
  - Button held high across reset produces no spurious press.
- Zero-latency response and illegal mode:
  - req_ready and rsp_valid high in the ISSUE cycle → DONE next cycle.
  - Mode 111 press leaves state IDLE.
